// File: rtl/motor_pwm_drv.sv
// H-bridge PWM driver: signed command -> magnitude/direction, edge-aligned PWM with dead time on reversal.
// Latency: outputs registered; a command takes effect at the next period boundary (plus DEADTIME on reversal).
// Backpressure: one-entry pending register; cmd_ready is low while it is full.
module motor_pwm_drv #(
    parameter int PERIOD   = 4095,
    parameter int DEADTIME = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [12:0] cmd,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        enable,
    output logic        out_a,
    output logic        out_b,
    output logic        period_start,
    output logic        sat
);

    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

    localparam logic [11:0] PER_M1 = 12'(PERIOD - 1);
    localparam logic [12:0] PER_13 = 13'(PERIOD);
    localparam logic [7:0]  DT_M1  = 8'(DEADTIME - 1);

    state_t      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic [7:0]  dcnt_q, dcnt_d;
    logic [11:0] duty_q, duty_d;
    logic        dir_q, dir_d;
    logic        sat_q, sat_d;
    logic        pend_full_q, pend_full_d;
    logic [11:0] pend_duty_q, pend_duty_d;
    logic        pend_dir_q, pend_dir_d;
    logic        pend_sat_q, pend_sat_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        out_a_q, out_a_d;
    logic        out_b_q, out_b_d;
    logic        ps_q, ps_d;

    logic [12:0] mag;
    logic        in_sat;
    logic [11:0] in_duty;
    logic        boundary;
    logic        load;
    logic        run_d;

    // -4096 folds to 4096, which fits in 13 bits unsigned
    assign mag     = cmd[12] ? (~cmd + 13'd1) : cmd;
    assign in_sat  = mag > PER_13;
    assign in_duty = in_sat ? PER_13[11:0] : mag[11:0];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dcnt_d      = dcnt_q;
        duty_d      = duty_q;
        dir_d       = dir_q;
        sat_d       = sat_q;
        pend_full_d = pend_full_q;
        pend_duty_d = pend_duty_q;
        pend_dir_d  = pend_dir_q;
        pend_sat_d  = pend_sat_q;
        boundary    = 1'b0;
        load        = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                duty_d = '0;
                sat_d  = 1'b0;
                if (enable) boundary = 1'b1;
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    duty_d  = '0;
                    sat_d   = 1'b0;
                end else if (cnt_q == PER_M1) begin
                    boundary = 1'b1;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            DEAD: begin
                if (!enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    duty_d  = '0;
                    sat_d   = 1'b0;
                end else if (dcnt_q == 8'd0) begin
                    load = pend_full_q;
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    dcnt_d = dcnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (boundary) begin
            state_d = RUN;
            cnt_d   = '0;
            // A zero-magnitude command never counts as a reversal
            if (pend_full_q) begin
                if ((pend_dir_q != dir_q) && (pend_duty_q != 12'd0)) begin
                    state_d = DEAD;
                    dcnt_d  = DT_M1;
                end else begin
                    load = 1'b1;
                end
            end
        end

        if (load) begin
            duty_d      = pend_duty_q;
            sat_d       = pend_sat_q;
            pend_full_d = 1'b0;
            if (pend_duty_q != 12'd0) dir_d = pend_dir_q;
        end

        if (cmd_valid && cmd_ready_q) begin
            pend_full_d = 1'b1;
            pend_duty_d = in_duty;
            pend_dir_d  = !cmd[12];
            pend_sat_d  = in_sat;
        end

        cmd_ready_d = !pend_full_d;
        run_d       = (state_d == RUN);
        out_a_d     = run_d && dir_d && (cnt_d < duty_d);
        out_b_d     = run_d && !dir_d && (cnt_d < duty_d);
        ps_d        = run_d && (cnt_d == 12'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dcnt_q      <= '0;
            duty_q      <= '0;
            dir_q       <= 1'b1;
            sat_q       <= 1'b0;
            pend_full_q <= 1'b0;
            pend_duty_q <= '0;
            pend_dir_q  <= 1'b1;
            pend_sat_q  <= 1'b0;
            cmd_ready_q <= 1'b1;
            out_a_q     <= 1'b0;
            out_b_q     <= 1'b0;
            ps_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dcnt_q      <= dcnt_d;
            duty_q      <= duty_d;
            dir_q       <= dir_d;
            sat_q       <= sat_d;
            pend_full_q <= pend_full_d;
            pend_duty_q <= pend_duty_d;
            pend_dir_q  <= pend_dir_d;
            pend_sat_q  <= pend_sat_d;
            cmd_ready_q <= cmd_ready_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            ps_q        <= ps_d;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign out_a        = out_a_q;
    assign out_b        = out_b_q;
    assign period_start = ps_q;
    assign sat          = sat_q;

endmodule

// File: tb/tb_motor_pwm_drv.sv
// Directed bench for motor_pwm_drv at PERIOD=100, DEADTIME=4; inputs driven and outputs sampled on the falling edge.
module tb_motor_pwm_drv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [12:0] cmd;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        enable;
    logic        out_a;
    logic        out_b;
    logic        period_start;
    logic        sat;

    int checks   = 0;
    int failures = 0;

    motor_pwm_drv #(.PERIOD(100), .DEADTIME(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd          (cmd),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .enable       (enable),
        .out_a        (out_a),
        .out_b        (out_b),
        .period_start (period_start),
        .sat          (sat)
    );

    initial forever #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_cmd(input logic [12:0] v);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_ready_timeout cmd_ready=%b required=1", cmd_ready);
        end
        cmd       = v;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_ps();
        int n = 0;
        while (period_start !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (period_start !== 1'b1) begin
            failures++;
            $display("FAIL period_start_timeout period_start=%b required=1", period_start);
        end
    endtask

    task automatic measure(output int na, output int nb, output int nps, output int nsat, output int nboth);
        na = 0; nb = 0; nps = 0; nsat = 0; nboth = 0;
        for (int i = 0; i < 100; i++) begin
            na    += int'(out_a === 1'b1);
            nb    += int'(out_b === 1'b1);
            nps   += int'(period_start === 1'b1);
            nsat  += int'(sat === 1'b1);
            nboth += int'(out_a === 1'b1 && out_b === 1'b1);
            tick();
            cmd_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd = '0; cmd_valid = 1'b0; enable = 1'b0;
        tick(); tick();
        checks++; if (out_a !== 1'b0) begin failures++; $display("FAIL reset_out_a got=%b want=0", out_a); end
        checks++; if (out_b !== 1'b0) begin failures++; $display("FAIL reset_out_b got=%b want=0", out_b); end
        checks++; if (period_start !== 1'b0) begin failures++; $display("FAIL reset_ps got=%b want=0", period_start); end
        checks++; if (sat !== 1'b0) begin failures++; $display("FAIL reset_sat got=%b want=0", sat); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
        rst_n = 1'b1;
        tick(); tick();
        checks++; if (out_a !== 1'b0 || period_start !== 1'b0) begin
            failures++; $display("FAIL idle_outputs out_a=%b ps=%b want=0,0", out_a, period_start);
        end
    endtask

    task automatic test_run25();
        int na, nb, nps, nsat, nboth;
        cmd = 13'd25; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0; enable = 1'b1;
        tick();
        checks++; if (period_start !== 1'b1 || out_a !== 1'b1) begin
            failures++; $display("FAIL run_entry ps=%b out_a=%b want=1,1", period_start, out_a);
        end
        measure(na, nb, nps, nsat, nboth);
        checks++; if (na !== 25) begin failures++; $display("FAIL run25_out_a count=%0d want=25", na); end
        checks++; if (nb !== 0) begin failures++; $display("FAIL run25_out_b count=%0d want=0", nb); end
        checks++; if (nps !== 1 || nsat !== 0) begin failures++; $display("FAIL run25_ps_sat ps=%0d sat=%0d want=1,0", nps, nsat); end
        checks++; if (period_start !== 1'b1) begin failures++; $display("FAIL run25_next_ps got=%b want=1", period_start); end
        measure(na, nb, nps, nsat, nboth);
        checks++; if (na !== 25 || nb !== 0) begin failures++; $display("FAIL run25_second a=%0d b=%0d want=25,0", na, nb); end
    endtask

    task automatic test_reverse();
        int na, nb, nps, nsat, nboth;
        int k = 0;
        int dead_high = 0;
        for (int i = 0; i < 50; i++) begin tick(); k++; end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rev_ready_before got=%b want=1", cmd_ready); end
        cmd = 13'h1FD8; cmd_valid = 1'b1;
        tick(); k++;
        cmd_valid = 1'b0;
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL rev_ready_after got=%b want=0", cmd_ready); end
        while (period_start !== 1'b1 && k < 400) begin
            if (k >= 100 && (out_a === 1'b1 || out_b === 1'b1)) dead_high++;
            tick(); k++;
        end
        checks++; if (k !== 104) begin failures++; $display("FAIL rev_dead_len cycles=%0d want=104", k); end
        checks++; if (dead_high !== 0) begin failures++; $display("FAIL rev_dead_low high_cycles=%0d want=0", dead_high); end
        measure(na, nb, nps, nsat, nboth);
        checks++; if (nb !== 40 || na !== 0) begin failures++; $display("FAIL rev_duty a=%0d b=%0d want=0,40", na, nb); end
        checks++; if (nsat !== 0 || nboth !== 0) begin failures++; $display("FAIL rev_sat_both sat=%0d both=%0d want=0,0", nsat, nboth); end
    endtask

    task automatic test_sat();
        int na, nb, nps, nsat, nboth;
        send_cmd(13'h1000);
        wait_ps();
        measure(na, nb, nps, nsat, nboth);
        checks++; if (nb !== 100 || na !== 0) begin failures++; $display("FAIL sat_neg_duty a=%0d b=%0d want=0,100", na, nb); end
        checks++; if (nsat !== 100) begin failures++; $display("FAIL sat_neg_flag count=%0d want=100", nsat); end
        send_cmd(13'd150);
        wait_ps();
        measure(na, nb, nps, nsat, nboth);
        checks++; if (na !== 100 || nb !== 0) begin failures++; $display("FAIL sat_pos_duty a=%0d b=%0d want=100,0", na, nb); end
        checks++; if (nsat !== 100 || nps !== 1) begin failures++; $display("FAIL sat_pos_flag sat=%0d ps=%0d want=100,1", nsat, nps); end
    endtask

    task automatic test_back_to_back();
        int na, nb, nps, nsat, nboth;
        int k = 0;
        for (int i = 0; i < 10; i++) begin tick(); k++; end
        cmd = 13'd30; cmd_valid = 1'b1;
        tick(); k++;
        cmd = 13'd60;
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL b2b_held got=%b want=0", cmd_ready); end
        while (cmd_ready !== 1'b1 && k < 400) begin tick(); k++; end
        checks++; if (k !== 100) begin failures++; $display("FAIL b2b_ready_rise cycle=%0d want=100", k); end
        checks++; if (period_start !== 1'b1 || out_a !== 1'b1) begin
            failures++; $display("FAIL b2b_boundary ps=%b out_a=%b want=1,1", period_start, out_a);
        end
        measure(na, nb, nps, nsat, nboth);
        checks++; if (na !== 30 || nsat !== 0) begin failures++; $display("FAIL b2b_first a=%0d sat=%0d want=30,0", na, nsat); end
        measure(na, nb, nps, nsat, nboth);
        checks++; if (na !== 60 || nb !== 0) begin failures++; $display("FAIL b2b_second a=%0d b=%0d want=60,0", na, nb); end
    endtask

    task automatic test_zero();
        int na, nb, nps, nsat, nboth;
        int k;
        send_cmd(13'h1FD8);
        wait_ps();
        measure(na, nb, nps, nsat, nboth);
        checks++; if (nb !== 40) begin failures++; $display("FAIL zero_pre b=%0d want=40", nb); end
        send_cmd(13'd0);
        wait_ps();
        measure(na, nb, nps, nsat, nboth);
        checks++; if (na !== 0 || nb !== 0 || nps !== 1) begin
            failures++; $display("FAIL zero_duty a=%0d b=%0d ps=%0d want=0,0,1", na, nb, nps);
        end
        send_cmd(13'h1FF6);
        k = 1;
        while (period_start !== 1'b1 && k < 400) begin tick(); k++; end
        checks++; if (k !== 100) begin failures++; $display("FAIL zero_no_dead cycles=%0d want=100", k); end
        measure(na, nb, nps, nsat, nboth);
        checks++; if (nb !== 10 || na !== 0) begin failures++; $display("FAIL zero_next a=%0d b=%0d want=0,10", na, nb); end
    endtask

    task automatic test_enable_drop();
        int na, nb, nps, nsat, nboth;
        int k;
        send_cmd(13'd70);
        for (int i = 0; i < 5; i++) tick();
        checks++; if (out_b !== 1'b1) begin failures++; $display("FAIL en_pre_out_b got=%b want=1", out_b); end
        enable = 1'b0;
        tick();
        checks++; if (out_b !== 1'b0 || out_a !== 1'b0) begin
            failures++; $display("FAIL en_drop_idle a=%b b=%b want=0,0", out_a, out_b);
        end
        tick(); tick(); tick();
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL en_pending_kept cmd_ready=%b want=0", cmd_ready); end
        enable = 1'b1;
        k = 0;
        while (period_start !== 1'b1 && k < 400) begin tick(); k++; end
        checks++; if (k !== 5) begin failures++; $display("FAIL en_resume_dead cycles=%0d want=5", k); end
        measure(na, nb, nps, nsat, nboth);
        checks++; if (na !== 70 || nb !== 0) begin failures++; $display("FAIL en_resume_duty a=%0d b=%0d want=70,0", na, nb); end
    endtask

    task automatic test_async_reset();
        send_cmd(13'h1FEC);
        for (int i = 0; i < 100; i++) tick();
        checks++; if (out_a !== 1'b0 || out_b !== 1'b0 || cmd_ready !== 1'b0) begin
            failures++; $display("FAIL dead_state a=%b b=%b rdy=%b want=0,0,0", out_a, out_b, cmd_ready);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1 || out_a !== 1'b0 || out_b !== 1'b0) begin
            failures++; $display("FAIL rst_mid_dead rdy=%b a=%b b=%b want=1,0,0", cmd_ready, out_a, out_b);
        end
        rst_n = 1'b1;
        tick();
        checks++; if (period_start !== 1'b1 || out_a !== 1'b0) begin
            failures++; $display("FAIL rst_restart ps=%b a=%b want=1,0", period_start, out_a);
        end
        send_cmd(13'd50);
        wait_ps();
        checks++; if (out_a !== 1'b1) begin failures++; $display("FAIL rst_pre_run out_a=%b want=1", out_a); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (out_a !== 1'b0 || period_start !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++; $display("FAIL rst_mid_run a=%b ps=%b rdy=%b want=0,0,1", out_a, period_start, cmd_ready);
        end
        rst_n = 1'b1;
        tick();
        checks++; if (out_a !== 1'b0 || out_b !== 1'b0) begin
            failures++; $display("FAIL rst_after_edge a=%b b=%b want=0,0", out_a, out_b);
        end
    endtask

    initial begin
        test_reset();
        test_run25();
        test_reverse();
        test_sat();
        test_back_to_back();
        test_zero();
        test_enable_drop();
        test_async_reset();
        enable = 1'b0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
